// File: rtl/any1_pkg.sv
// Shared types for the any1 core: operand/instruction widths and the
// address-generator result record.
package any1_pkg;
    typedef logic [31:0] Instruction;
    typedef logic [63:0] Value;

    localparam int AWID = 32;
    localparam int AGEN_SCHED_NREQ_MAX = 8;
    localparam int AGEN_TAG_MAX = 8;
    localparam int AGEN_SRC_W = $clog2(AGEN_SCHED_NREQ_MAX);

    typedef struct packed {
        logic [AWID-1:0]         ea;
        logic [AGEN_TAG_MAX-1:0] tag;
        logic [AGEN_SRC_W-1:0]   src;
    } agen_res_t;
endpackage

// File: rtl/any1_agen_sched_if.sv
// Request, agen operand and result buses of the agen scheduler.
// slave = scheduler side, master = requesters/agen/consumer side.
interface any1_agen_sched_if
    import any1_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int TAGW = 5
);
    localparam int IW = $clog2(NREQ);

    logic [NREQ-1:0]            req_valid;
    Instruction [NREQ-1:0]      req_ir;
    Value [NREQ-1:0]            req_ia;
    Value [NREQ-1:0]            req_ib;
    logic [NREQ-1:0][TAGW-1:0]  req_tag;
    logic [NREQ-1:0]            req_ready;
    Instruction                 agen_ir;
    Value                       agen_ia;
    Value                       agen_ib;
    logic [AWID-1:0]            agen_ea;
    logic                       res_valid;
    logic [AWID-1:0]            res_ea;
    logic [TAGW-1:0]            res_tag;
    logic [IW-1:0]              res_src;
    logic                       res_ready;

    modport slave (
        input  req_valid, req_ir, req_ia, req_ib, req_tag, agen_ea, res_ready,
        output req_ready, agen_ir, agen_ia, agen_ib,
        output res_valid, res_ea, res_tag, res_src
    );

    modport master (
        output req_valid, req_ir, req_ia, req_ib, req_tag, agen_ea, res_ready,
        input  req_ready, agen_ir, agen_ia, agen_ib,
        input  res_valid, res_ea, res_tag, res_src
    );
endinterface

// File: rtl/any1_agen_rrarb.sv
// Round-robin find-first-from-pointer arbiter, purely combinational.
module any1_agen_rrarb #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt_onehot,
    output logic [IW-1:0]   gnt_idx,
    output logic            gnt_any
);
    always_comb begin
        int j;
        j = 0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            j = (int'(ptr) + i) % NREQ;
            if (!gnt_any && req[j]) begin
                gnt_any = 1'b1;
                gnt_idx = IW'(j);
            end
        end
        gnt_onehot = gnt_any ? (NREQ'(1) << gnt_idx) : '0;
    end
endmodule

// File: rtl/any1_agen_sched.sv
// Round-robin scheduler sharing one agen among NREQ requesters, with a
// credit-controlled result FIFO. Optional counters: ANY1_AGEN_PERFCNT_EN.
module any1_agen_sched
    import any1_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int TAGW  = 5,
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    any1_agen_sched_if.slave bus
`ifdef ANY1_AGEN_PERFCNT_EN
    ,
    output logic [NREQ-1:0][31:0] perf_grants,
    output logic [31:0]           perf_stall
`endif
);
    localparam int IW = $clog2(NREQ);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [IW-1:0]   rr_q, rr_d;
    logic            infl_q, infl_d;
    logic [TAGW-1:0] s1_tag_q, s1_tag_d;
    logic [IW-1:0]   s1_src_q, s1_src_d;
    agen_res_t       mem_q [DEPTH];
    agen_res_t       mem_d [DEPTH];
    logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    agen_res_t       last_q, last_d;

    logic [NREQ-1:0] gnt_oh;
    logic [IW-1:0]   gnt_idx;
    logic            gnt_any;
    logic            credit_ok, grant, push, pop, full;
    agen_res_t       head, sel;

    any1_agen_rrarb #(.NREQ(NREQ), .IW(IW)) u_arb (
        .req        (bus.req_valid),
        .ptr        (rr_q),
        .gnt_onehot (gnt_oh),
        .gnt_idx    (gnt_idx),
        .gnt_any    (gnt_any)
    );

    assign head          = mem_q[rd_q];
    assign bus.res_valid = cnt_q != '0;
    assign pop           = bus.res_valid && bus.res_ready;
    assign push          = infl_q && !flush;
    assign full          = cnt_q == CW'(DEPTH);
    // A pop this cycle frees a slot in time for the op issued now.
    assign credit_ok     = ((int'(cnt_q) + int'(infl_q)) < DEPTH) || pop;
    assign grant         = rst && !flush && credit_ok && gnt_any;

    assign bus.req_ready = grant ? gnt_oh : '0;
    assign bus.agen_ir   = grant ? bus.req_ir[gnt_idx] : '0;
    assign bus.agen_ia   = grant ? bus.req_ia[gnt_idx] : '0;
    assign bus.agen_ib   = grant ? bus.req_ib[gnt_idx] : '0;

    assign sel         = bus.res_valid ? head : last_q;
    assign bus.res_ea  = sel.ea;
    assign bus.res_tag = TAGW'(sel.tag);
    assign bus.res_src = IW'(sel.src);

    always_comb begin
        rr_d     = rr_q;
        infl_d   = grant;
        s1_tag_d = s1_tag_q;
        s1_src_d = s1_src_q;
        mem_d    = mem_q;
        wr_d     = wr_q;
        rd_d     = rd_q;
        last_d   = last_q;
        if (grant) begin
            rr_d     = (gnt_idx == IW'(NREQ - 1)) ? '0 : IW'(gnt_idx + 1'b1);
            s1_tag_d = bus.req_tag[gnt_idx];
            s1_src_d = gnt_idx;
        end
        if (push) begin
            mem_d[wr_q] = '{ea:  bus.agen_ea,
                            tag: AGEN_TAG_MAX'(s1_tag_q),
                            src: AGEN_SRC_W'(s1_src_q)};
            wr_d = wr_q + 1'b1;
        end
        if (pop) begin
            last_d = head;
            rd_d   = rd_q + 1'b1;
        end
        cnt_d = cnt_q + CW'(push) - CW'(pop);
        if (flush) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_q     <= '0;
            infl_q   <= 1'b0;
            s1_tag_q <= '0;
            s1_src_q <= '0;
            wr_q     <= '0;
            rd_q     <= '0;
            cnt_q    <= '0;
            last_q   <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            rr_q     <= rr_d;
            infl_q   <= infl_d;
            s1_tag_q <= s1_tag_d;
            s1_src_q <= s1_src_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            mem_q    <= mem_d;
        end
    end

    a_no_overflow: assert property (
        @(posedge clk) disable iff (!rst) !(push && full && !pop));

`ifdef ANY1_AGEN_PERFCNT_EN
    logic [NREQ-1:0][31:0] perf_grants_q, perf_grants_d;
    logic [31:0]           perf_stall_q, perf_stall_d;

    always_comb begin
        perf_grants_d = perf_grants_q;
        perf_stall_d  = perf_stall_q;
        for (int i = 0; i < NREQ; i++) begin
            if (bus.req_ready[i] && perf_grants_q[i] != '1)
                perf_grants_d[i] = perf_grants_q[i] + 1'b1;
        end
        if (rst && |bus.req_valid && !credit_ok && perf_stall_q != '1)
            perf_stall_d = perf_stall_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_grants_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            perf_grants_q <= perf_grants_d;
            perf_stall_q  <= perf_stall_d;
        end
    end

    assign perf_grants = perf_grants_q;
    assign perf_stall  = perf_stall_q;
`endif
endmodule

// File: tb/tb_any1_agen_sched.sv
// Directed bench for any1_agen_sched: reset, round robin, sparse,
// backpressure, flush; result stream checked against an expected queue.
module tb_any1_agen_sched;
    import any1_pkg::*;

    logic clk;
    logic rst;
    logic flush;
    int   n_chk;
    int   n_err;
    int   exp_q[$];

    any1_agen_sched_if #(.NREQ(4), .TAGW(5)) bus ();

`ifdef ANY1_AGEN_PERFCNT_EN
    logic [3:0][31:0] perf_grants;
    logic [31:0]      perf_stall;
`endif

    any1_agen_sched #(.NREQ(4), .TAGW(5), .DEPTH(2)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
`ifdef ANY1_AGEN_PERFCNT_EN
        ,
        .perf_grants (perf_grants),
        .perf_stall  (perf_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic Instruction ir_of(int i);
        Instruction ir;
        ir = '0;
        ir[31:20] = 12'(16 * i + 1);
        ir[13:12] = 2'(i);
        return ir;
    endfunction

    function automatic Value ia_of(int i);
        return 64'(32'h1000 * (i + 1));
    endfunction

    function automatic Value ib_of(int i);
        return 64'(i + 3);
    endfunction

    function automatic logic [4:0] tag_of(int i);
        return 5'(8 + i);
    endfunction

    // Behavioural agen: ea = disp + ia + (ib << sc)
    function automatic logic [31:0] agen_f(Instruction ir, Value ia, Value ib);
        logic [31:0] disp;
        disp = {{20{ir[31]}}, ir[31:20]};
        return disp + ia[31:0] + (ib[31:0] << ir[13:12]);
    endfunction

    always @(posedge clk)
        bus.agen_ea <= agen_f(bus.agen_ir, bus.agen_ia, bus.agen_ib);

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst && bus.res_valid && bus.res_ready) begin
            if (exp_q.size() == 0) begin
                check("res_extra", 64'(bus.res_src), 64'hffff);
            end else begin
                int e;
                e = exp_q.pop_front();
                check("res_src", 64'(bus.res_src), 64'(e));
                check("res_tag", 64'(bus.res_tag), 64'(tag_of(e)));
                check("res_ea", 64'(bus.res_ea),
                      64'(agen_f(ir_of(e), ia_of(e), ib_of(e))));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] sp_exp [3];
        n_chk = 0;
        n_err = 0;
        for (int i = 0; i < 4; i++) begin
            bus.req_ir[i]  = ir_of(i);
            bus.req_ia[i]  = ia_of(i);
            bus.req_ib[i]  = ib_of(i);
            bus.req_tag[i] = tag_of(i);
        end
        bus.req_valid = 4'b1111;
        bus.res_ready = 1'b1;
        flush = 1'b0;
        rst = 1'b1;
        #2 rst = 1'b0;
        step();
        step();
        @(negedge clk);
        check("rst_ready", 64'(bus.req_ready), 64'h0);
        check("rst_valid", 64'(bus.res_valid), 64'h0);
        check("rst_ea", 64'(bus.res_ea), 64'h0);
        check("rst_tag", 64'(bus.res_tag), 64'h0);
        check("rst_src", 64'(bus.res_src), 64'h0);
        check("rst_agen_ia", bus.agen_ia, 64'h0);
        step();
        rst = 1'b1;

        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("rr_gnt", 64'(bus.req_ready), 64'(4'b0001 << (k % 4)));
            check("rr_agen_ia", bus.agen_ia, ia_of(k % 4));
            check("rr_agen_ir", 64'(bus.agen_ir), 64'(ir_of(k % 4)));
            exp_q.push_back(k % 4);
            step();
        end
        bus.req_valid = 4'b0000;
        repeat (3) step();
        @(negedge clk);
        check("rr_drain", 64'(bus.res_valid), 64'h0);
        check("rr_idle_agen", bus.agen_ib, 64'h0);
        step();

        bus.req_valid = 4'b0010;
        @(negedge clk);
        check("sp_gnt1", 64'(bus.req_ready), 64'b0010);
        exp_q.push_back(1);
        step();
        bus.req_valid = 4'b1010;
        sp_exp[0] = 4'b1000;
        sp_exp[1] = 4'b0010;
        sp_exp[2] = 4'b1000;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("sp_gnt", 64'(bus.req_ready), 64'(sp_exp[k]));
            exp_q.push_back(sp_exp[k] == 4'b1000 ? 3 : 1);
            step();
        end
        bus.req_valid = 4'b0000;
        repeat (3) step();

        rst = 1'b0;
        bus.req_valid = 4'b1111;
        @(negedge clk);
        check("rst2_ready", 64'(bus.req_ready), 64'h0);
        step();
        rst = 1'b1;
        bus.res_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("bp_gnt", 64'(bus.req_ready),
                  k == 0 ? 64'b0001 : (k == 1 ? 64'b0010 : 64'h0));
            if (k < 2) exp_q.push_back(k);
            step();
        end
        check("bp_full", 64'(bus.res_valid), 64'h1);
`ifdef ANY1_AGEN_PERFCNT_EN
        check("perf_stall", 64'(perf_stall), 64'd8);
        check("perf_g0", 64'(perf_grants[0]), 64'd1);
        check("perf_g1", 64'(perf_grants[1]), 64'd1);
        check("perf_g2", 64'(perf_grants[2]), 64'd0);
`endif
        bus.res_ready = 1'b1;
        @(negedge clk);
        check("bp_pop_gnt", 64'(bus.req_ready), 64'b0100);
        exp_q.push_back(2);
        step();
        @(negedge clk);
        check("bp_pop_gnt2", 64'(bus.req_ready), 64'b1000);
        exp_q.push_back(3);
        step();
        bus.req_valid = 4'b0000;
        repeat (4) step();
        @(negedge clk);
        check("bp_drain", 64'(bus.res_valid), 64'h0);
        check("bp_sb", 64'(exp_q.size()), 64'h0);
        step();

        bus.res_ready = 1'b0;
        bus.req_valid = 4'b0001;
        @(negedge clk);
        check("fl_gnt0", 64'(bus.req_ready), 64'b0001);
        step();
        bus.req_valid = 4'b0100;
        @(negedge clk);
        check("fl_gnt2", 64'(bus.req_ready), 64'b0100);
        check("fl_tag_in", 64'(bus.req_tag[2]), 64'h0a);
        step();
        flush = 1'b1;
        @(negedge clk);
        check("fl_nogrant", 64'(bus.req_ready), 64'h0);
        check("fl_queued", 64'(bus.res_valid), 64'h1);
        step();
        flush = 1'b0;
        bus.req_valid = 4'b0000;
        @(negedge clk);
        check("fl_empty", 64'(bus.res_valid), 64'h0);
        step();
        @(negedge clk);
        check("fl_dropped", 64'(bus.res_valid), 64'h0);
        step();
        bus.req_valid = 4'b1111;
        bus.res_ready = 1'b1;
        @(negedge clk);
        check("fl_rr_kept", 64'(bus.req_ready), 64'b1000);
        exp_q.push_back(3);
        step();
        bus.req_valid = 4'b0000;
        repeat (3) step();
        @(negedge clk);
        check("end_empty", 64'(bus.res_valid), 64'h0);
        check("end_sb", 64'(exp_q.size()), 64'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
